// File: rtl/gray_window_buffer.sv
// gray_window_buffer: 3x3 grayscale window between grayscale and Sobel stages.
// Ports: clk, n_rst (async low); i_frame_start/i_b1_save/i_b1_clear pulses,
//   i_gray_pixel in; o_b1_full, o_window (slot k at [PIXEL_W*k +: PIXEL_W]),
//   o_count, o_overflow out. Optional: GRAY_WINDOW_BUFFER_OVF_EN.
module gray_window_buffer #(
  parameter int PIXEL_W = 8,
  parameter int WIN     = 3
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_frame_start,
  input  logic                       i_b1_save,
  input  logic                       i_b1_clear,
  input  logic [PIXEL_W-1:0]         i_gray_pixel,
  output logic                       o_b1_full,
  output logic [WIN*WIN*PIXEL_W-1:0] o_window,
  output logic [3:0]                 o_count,
  output logic                       o_overflow
);

  localparam int N = WIN * WIN;
  localparam logic [3:0] CNT_FULL = 4'(N);
  localparam logic [3:0] COL = 4'(WIN);

  typedef enum logic {
    FILL,
    FULL
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0][PIXEL_W-1:0] win_q, win_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= FILL;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slide/clear happens first, so a coincident save lands
  // in the slot named by the post-slide count.
  always_comb begin
    win_d = win_q;
    cnt_d = cnt_q;
    if (i_frame_start) begin
      win_d = '0;
      cnt_d = '0;
    end else if (i_b1_clear) begin
      if (cnt_q >= COL) begin
        for (int k = 0; k < N - WIN; k++)
          win_d[k] = win_q[k+WIN];
        for (int k = N - WIN; k < N; k++)
          win_d[k] = '0;
        cnt_d = cnt_q - COL;
      end else begin
        win_d = '0;
        cnt_d = '0;
      end
    end
    if (i_b1_save && cnt_d != CNT_FULL) begin
      for (int k = 0; k < N; k++)
        if (4'(k) == cnt_d)
          win_d[k] = i_gray_pixel;
      cnt_d = cnt_d + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (cnt_d == CNT_FULL) state_d = FULL;
      FULL: if (i_frame_start || i_b1_clear) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  assign o_b1_full = (state_q == FULL);
  assign o_window  = win_q;
  assign o_count   = cnt_q;

`ifdef GRAY_WINDOW_BUFFER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      ovf_q <= 1'b0;
    else if (i_frame_start)
      ovf_q <= 1'b0;
    else if (i_b1_save && state_q == FULL)
      ovf_q <= 1'b1;
  end

  assign o_overflow = ovf_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_gray_window_buffer.sv
// tb_gray_window_buffer: directed + random checks of gray_window_buffer
// against a queue-of-valid-pixels reference model.
module tb_gray_window_buffer;

  localparam int PW = 8;
  localparam int WW = 9 * PW;

`ifdef GRAY_WINDOW_BUFFER_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic          i_frame_start;
  logic          i_b1_save;
  logic          i_b1_clear;
  logic [PW-1:0] i_gray_pixel;
  logic          o_b1_full;
  logic [WW-1:0] o_window;
  logic [3:0]    o_count;
  logic          o_overflow;

  int total = 0;
  int bad = 0;

  logic [PW-1:0] mq[$];
  bit            movf;

  gray_window_buffer #(.PIXEL_W(PW), .WIN(3)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_frame_start(i_frame_start),
    .i_b1_save    (i_b1_save),
    .i_b1_clear   (i_b1_clear),
    .i_gray_pixel (i_gray_pixel),
    .o_b1_full    (o_b1_full),
    .o_window     (o_window),
    .o_count      (o_count),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [WW-1:0] obs,
                     input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] mwin();
    logic [WW-1:0] w = '0;
    for (int k = 0; k < mq.size(); k++)
      w[k*PW +: PW] = mq[k];
    return w;
  endfunction

  // Model: window is the list of valid pixels, oldest first;
  // a slide drops the oldest column (3 pixels).
  task automatic model(input bit fs, input bit clr,
                       input bit sav, input logic [PW-1:0] pix);
    if (sav && !fs && mq.size() == 9 && OVF) movf = 1'b1;
    if (fs) begin
      mq.delete();
      movf = 1'b0;
    end else if (clr) begin
      if (mq.size() >= 3)
        repeat (3) void'(mq.pop_front());
      else
        mq.delete();
    end
    if (sav && mq.size() < 9) mq.push_back(pix);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, WW'(o_count), WW'(mq.size()));
    chk({tag, ".full"}, WW'(o_b1_full), WW'(mq.size() == 9));
    chk({tag, ".win"}, o_window, mwin());
    chk({tag, ".ovf"}, WW'(o_overflow), WW'(movf));
  endtask

  task automatic step(input string tag, input bit fs, input bit clr,
                      input bit sav, input logic [PW-1:0] pix);
    @(negedge clk);
    i_frame_start = fs;
    i_b1_clear    = clr;
    i_b1_save     = sav;
    i_gray_pixel  = pix;
    model(fs, clr, sav, pix);
    @(posedge clk);
    #1;
    i_frame_start = 1'b0;
    i_b1_clear    = 1'b0;
    i_b1_save     = 1'b0;
    check_all(tag);
  endtask

  task automatic fill9(input string tag, input logic [PW-1:0] base);
    for (int i = 0; i < 9; i++)
      step(tag, 0, 0, 1, base + PW'(i));
  endtask

  logic [WW-1:0] ew;

  initial begin
    n_rst = 1'b0;
    i_frame_start = 1'b0;
    i_b1_save = 1'b0;
    i_b1_clear = 1'b0;
    i_gray_pixel = '0;
    movf = 1'b0;
    #12;
    chk("rst.count", WW'(o_count), '0);
    chk("rst.full", WW'(o_b1_full), '0);
    chk("rst.win", o_window, '0);
    chk("rst.ovf", WW'(o_overflow), '0);
    @(negedge clk);
    n_rst = 1'b1;

    // 1: nine saves with idle gaps
    for (int i = 0; i < 9; i++) begin
      step("t1.save", 0, 0, 1, 8'h10 + 8'(i));
      chk("t1.cnt", WW'(o_count), WW'(i + 1));
      step("t1.idle", 0, 0, 0, 8'h00);
    end
    ew = '0;
    for (int k = 0; k < 9; k++) ew[k*PW +: PW] = 8'h10 + 8'(k);
    chk("t1.win_const", o_window, ew);
    chk("t1.full_const", WW'(o_b1_full), WW'(1));

    // 2: slide then refill
    step("t2.clr", 0, 1, 0, 8'h00);
    ew = '0;
    for (int k = 0; k < 6; k++) ew[k*PW +: PW] = 8'h13 + 8'(k);
    chk("t2.win_const", o_window, ew);
    chk("t2.cnt_const", WW'(o_count), WW'(6));
    for (int i = 0; i < 3; i++) step("t2.save", 0, 0, 1, 8'h20 + 8'(i));
    for (int k = 6; k < 9; k++) ew[k*PW +: PW] = 8'h20 + 8'(k - 6);
    chk("t2.win_refill", o_window, ew);
    chk("t2.full_const", WW'(o_b1_full), WW'(1));

    // 3: clear + save together from full
    step("t3.clrsave", 0, 1, 1, 8'h55);
    chk("t3.slot6", WW'(o_window[6*PW +: PW]), WW'(8'h55));
    chk("t3.cnt_const", WW'(o_count), WW'(7));

    // 4: save while full, overflow
    step("t4.s7", 0, 0, 1, 8'h60);
    step("t4.s8", 0, 0, 1, 8'h61);
    ew = o_window;
    step("t4.ovf_save", 0, 0, 1, 8'hAA);
    chk("t4.win_same", o_window, ew);
    chk("t4.ovf_const", WW'(o_overflow), WW'(OVF));
    step("t4.clr", 0, 1, 0, 8'h00);
    chk("t4.ovf_hold", WW'(o_overflow), WW'(OVF));
    step("t4.fs", 1, 0, 0, 8'h00);
    chk("t4.ovf_fs", WW'(o_overflow), WW'(0));
    fill9("t4.refill", 8'h80);
    step("t4.clrsave_full", 0, 1, 1, 8'h99);
    chk("t4.ovf_clrsave", WW'(o_overflow), WW'(OVF));

    // 5: frame_start with save
    step("t5.fs0", 1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step("t5.save", 0, 0, 1, 8'h40 + 8'(i));
    step("t5.fs_save", 1, 0, 1, 8'h77);
    chk("t5.win_const", o_window, WW'(8'h77));
    chk("t5.cnt_const", WW'(o_count), WW'(1));

    // 6: async reset mid-cycle
    for (int i = 0; i < 3; i++) step("t6.save", 0, 0, 1, 8'h30 + 8'(i));
    #2;
    n_rst = 1'b0;
    #1;
    chk("t6.rst.count", WW'(o_count), '0);
    chk("t6.rst.full", WW'(o_b1_full), '0);
    chk("t6.rst.win", o_window, '0);
    chk("t6.rst.ovf", WW'(o_overflow), '0);
    mq.delete();
    movf = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    step("t6.after", 0, 0, 1, 8'h3C);
    chk("t6.slot0", o_window, WW'(8'h3C));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", $urandom_range(0, 31) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, PW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
